// File: rtl/ex.sv
// Execute stage: logic/shift/move/arith ALU plus a 32-cycle restoring divider
// that stalls the front of the pipeline while it iterates.
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        wreg_i,
  input  logic [4:0]  wd_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [2:0] SelNop   = 3'b000;
  localparam logic [2:0] SelLogic = 3'b001;
  localparam logic [2:0] SelShift = 3'b010;
  localparam logic [2:0] SelMove  = 3'b011;
  localparam logic [2:0] SelArith = 3'b100;

  localparam logic [7:0] OpAnd  = 8'h24;
  localparam logic [7:0] OpOr   = 8'h25;
  localparam logic [7:0] OpXor  = 8'h26;
  localparam logic [7:0] OpNor  = 8'h27;
  localparam logic [7:0] OpSll  = 8'h7C;
  localparam logic [7:0] OpSrl  = 8'h02;
  localparam logic [7:0] OpSra  = 8'h03;
  localparam logic [7:0] OpAdd  = 8'h20;
  localparam logic [7:0] OpAddu = 8'h21;
  localparam logic [7:0] OpSubu = 8'h23;
  localparam logic [7:0] OpSlt  = 8'h2A;
  localparam logic [7:0] OpMfhi = 8'h10;
  localparam logic [7:0] OpMthi = 8'h11;
  localparam logic [7:0] OpMflo = 8'h12;
  localparam logic [7:0] OpMtlo = 8'h13;
  localparam logic [7:0] OpDiv  = 8'h1A;
  localparam logic [7:0] OpDivu = 8'h1B;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] rem_q, rem_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;

  logic        is_div, div_op;
  logic [32:0] trial, diff;
  logic [31:0] quot_res, rem_res;
  logic [31:0] logic_res, shift_res, move_res, arith_res, sum;
  logic        add_ovf;

  assign is_div = (aluop_i == OpDiv);
  assign div_op = is_div || (aluop_i == OpDivu);

  // Remainder stays below the divisor, so a borrow out of bit 32 means "does not fit".
  assign trial = {rem_q, dvd_q[31]};
  assign diff  = trial - {1'b0, dsr_q};

  assign quot_res = neg_quot_q ? (32'd0 - dvd_q) : dvd_q;
  assign rem_res  = neg_rem_q ? (32'd0 - rem_q) : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    unique case (state_q)
      StIdle: begin
        if (div_op) begin
          if (reg2_i == 32'd0) begin
            dvd_d      = '0;
            rem_d      = '0;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            state_d    = StDone;
          end else begin
            dvd_d      = (is_div && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
            dsr_d      = (is_div && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;
            rem_d      = '0;
            cnt_d      = '0;
            neg_quot_d = is_div && (reg1_i[31] ^ reg2_i[31]);
            neg_rem_d  = is_div && reg1_i[31];
            state_d    = StBusy;
          end
        end
      end
      StBusy: begin
        // Dividend register shifts left and collects quotient bits at the bottom.
        dvd_d = {dvd_q[30:0], ~diff[32]};
        rem_d = diff[32] ? trial[31:0] : diff[31:0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      OpAnd:   logic_res = reg1_i & reg2_i;
      OpOr:    logic_res = reg1_i | reg2_i;
      OpXor:   logic_res = reg1_i ^ reg2_i;
      OpNor:   logic_res = ~(reg1_i | reg2_i);
      default: logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      OpSll:   shift_res = reg2_i << reg1_i[4:0];
      OpSrl:   shift_res = reg2_i >> reg1_i[4:0];
      OpSra:   shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      default: shift_res = '0;
    endcase
  end

  always_comb begin
    move_res = '0;
    case (aluop_i)
      OpMfhi:  move_res = hi_i;
      OpMflo:  move_res = lo_i;
      default: move_res = '0;
    endcase
  end

  assign sum     = reg1_i + reg2_i;
  assign add_ovf = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      OpAdd, OpAddu: arith_res = sum;
      OpSubu:        arith_res = reg1_i - reg2_i;
      OpSlt:         arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      default:       arith_res = '0;
    endcase
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (rst) begin
      wd_o   = wd_i;
      wreg_o = wreg_i;
      case (alusel_i)
        SelLogic: wdata_o = logic_res;
        SelShift: wdata_o = shift_res;
        SelMove:  wdata_o = move_res;
        SelArith: wdata_o = arith_res;
        SelNop:   wdata_o = '0;
        default:  wdata_o = '0;
      endcase
      if (aluop_i == OpAdd && add_ovf) wreg_o = 1'b0;
      if (div_op || state_q != StIdle) wreg_o = 1'b0;
      stallreq_o = (state_q == StBusy) || (state_q == StIdle && div_op);
      if (state_q == StDone) begin
        whilo_o = 1'b1;
        hi_o    = rem_res;
        lo_o    = quot_res;
      end else if (aluop_i == OpMthi) begin
        whilo_o = 1'b1;
        hi_o    = reg1_i;
        lo_o    = lo_i;
      end else if (aluop_i == OpMtlo) begin
        whilo_o = 1'b1;
        hi_o    = hi_i;
        lo_o    = reg1_i;
      end
    end
  end

endmodule

// File: tb/tb_ex.sv
// Scoreboarded bench for ex: ALU results, HI/LO moves, divider latency and reset abort.
module tb_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
  logic        wreg_i;
  logic [4:0]  wd_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  typedef struct {
    logic [31:0] wdata;
    logic        wreg;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ex dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wreg_i     (wreg_i),
    .wd_i       (wd_i),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
  endtask

  task automatic run_alu(input string name, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_wd,
                         input logic exp_wreg);
    exp_t e;
    @(negedge clk);
    drive(op, sel, a, b);
    wreg_i = 1'b1;
    sb.push_back('{wdata: exp_wd, wreg: exp_wreg, whilo: 1'b0, hi: 32'd0, lo: 32'd0, stalls: 0});
    #1;
    e = sb.pop_front();
    check({name, ".wdata"}, wdata_o, e.wdata);
    check({name, ".wreg"}, {31'd0, wreg_o}, {31'd0, e.wreg});
  endtask

  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_stalls);
    exp_t e;
    int   stalls;
    @(negedge clk);
    drive(op, 3'b000, a, b);
    wreg_i = 1'b1;
    sb.push_back('{wdata: 32'd0, wreg: 1'b0, whilo: 1'b1, hi: exp_hi, lo: exp_lo,
                   stalls: exp_stalls});
    #1;
    check({name, ".issue_wreg"}, {31'd0, wreg_o}, 32'd0);
    stalls = 0;
    while (stallreq_o && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    e = sb.pop_front();
    check({name, ".stall_cycles"}, stalls, e.stalls);
    check({name, ".whilo"}, {31'd0, whilo_o}, {31'd0, e.whilo});
    check({name, ".lo"}, lo_o, e.lo);
    check({name, ".hi"}, hi_o, e.hi);
    check({name, ".done_wreg"}, {31'd0, wreg_o}, {31'd0, e.wreg});
    @(negedge clk);
    drive(8'h00, 3'b000, 32'd0, 32'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, ".wdata"}, wdata_o, 32'd0);
    check({name, ".wreg"}, {31'd0, wreg_o}, 32'd0);
    check({name, ".wd"}, {27'd0, wd_o}, 32'd0);
    check({name, ".stall"}, {31'd0, stallreq_o}, 32'd0);
    check({name, ".whilo"}, {31'd0, whilo_o}, 32'd0);
    check({name, ".hi"}, hi_o, 32'd0);
    check({name, ".lo"}, lo_o, 32'd0);
  endtask

  initial begin
    rst    = 1'b0;
    drive(8'h24, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wreg_i = 1'b1;
    wd_i   = 5'h1F;
    hi_i   = 32'hAAAA_5555;
    lo_i   = 32'hCAFE_BABE;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("wd_pass", {27'd0, wd_o}, 32'h1F);

    run_alu("add_ovf", 8'h20, 3'b100, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
    run_alu("addu", 8'h21, 3'b100, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
    run_alu("add_ok", 8'h20, 3'b100, 32'd5, 32'hFFFF_FFFE, 32'd3, 1'b1);
    run_alu("subu", 8'h23, 3'b100, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1);
    run_alu("slt_neg", 8'h2A, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
    run_alu("slt_pos", 8'h2A, 3'b100, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    run_alu("sra", 8'h03, 3'b010, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b1);
    run_alu("srl", 8'h02, 3'b010, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b1);
    run_alu("sll_amt5", 8'h7C, 3'b010, 32'h24, 32'd1, 32'h10, 1'b1);
    run_alu("and", 8'h24, 3'b001, 32'hF0F0_1234, 32'h0FF0_5678, 32'h00F0_1230, 1'b1);
    run_alu("or", 8'h25, 3'b001, 32'hF0F0_1234, 32'h0FF0_5678, 32'hFFF0_567C, 1'b1);
    run_alu("xor", 8'h26, 3'b001, 32'hF0F0_1234, 32'h0FF0_5678, 32'hFF00_444C, 1'b1);
    run_alu("nor", 8'h27, 3'b001, 32'hF0F0_1234, 32'h0FF0_5678, 32'h000F_A983, 1'b1);
    run_alu("bad_op", 8'h55, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
    run_alu("nop_sel", 8'h24, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
    run_alu("mfhi", 8'h10, 3'b011, 32'd0, 32'd0, 32'hAAAA_5555, 1'b1);
    run_alu("mflo", 8'h12, 3'b011, 32'd0, 32'd0, 32'hCAFE_BABE, 1'b1);

    @(negedge clk);
    drive(8'h11, 3'b011, 32'h1234_5678, 32'd0);
    #1;
    check("mthi.whilo", {31'd0, whilo_o}, 32'd1);
    check("mthi.hi", hi_o, 32'h1234_5678);
    check("mthi.lo", lo_o, 32'hCAFE_BABE);
    @(negedge clk);
    drive(8'h13, 3'b011, 32'h8765_4321, 32'd0);
    #1;
    check("mtlo.hi", hi_o, 32'hAAAA_5555);
    check("mtlo.lo", lo_o, 32'h8765_4321);
    @(negedge clk);
    drive(8'h21, 3'b100, 32'd1, 32'd1);
    #1;
    check("addu.whilo", {31'd0, whilo_o}, 32'd0);

    run_div("divu", 8'h1B, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("div_neg", 8'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("div_zero", 8'h1A, 32'd55, 32'd0, 32'd0, 32'd0, 1);
    run_div("div_negdsr", 8'h1A, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd2, 33);

    // Abort a divide ten cycles into BUSY.
    @(negedge clk);
    drive(8'h1B, 3'b000, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    #1;
    check("abort.busy_stall", {31'd0, stallreq_o}, 32'd1);
    rst = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clk);
    rst = 1'b1;
    drive(8'h00, 3'b000, 32'd0, 32'd0);
    #1;
    check("abort.idle_stall", {31'd0, stallreq_o}, 32'd0);
    check("abort.idle_whilo", {31'd0, whilo_o}, 32'd0);
    run_div("divu_post", 8'h1B, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
